// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard-unit addresses and the
// ID/EX register outputs. master is the decode stage, slave is its environment.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            StallE;
    logic            FlushE;
    logic            RegWriteW;
    logic [AW-1:0]   RdW;
    logic [XLEN-1:0] ResultW;

    logic [AW-1:0]   Rs1D;
    logic [AW-1:0]   Rs2D;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            ALUSrcE;
    logic            ValidE;
    logic            IllegalE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [2:0]      Funct3E;
    logic [AW-1:0]   Rs1E;
    logic [AW-1:0]   Rs2E;
    logic [AW-1:0]   RdE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;

    modport master (
        input  InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE, RegWriteW, RdW, ResultW,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE,
               ResultSrcE, ALUControlE, Funct3E, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E
    );

    modport slave (
        output InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE, RegWriteW, RdW, ResultW,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE,
               ResultSrcE, ALUControlE, Funct3E, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I-subset decode stage: register file with optional write-to-read bypass,
// control/immediate decode, and the ID/EX pipeline register.
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset,
    decode_stage_if.master bus
);
    localparam int   AW        = $clog2(NREGS);
    localparam logic BYPASS_EN = (BYPASS != 32'sd0);

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011,
        ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000, ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010
    } aluOp_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_J = 3'd4, IMM_U = 3'd5
    } immSel_e;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic       aluSrc;
        logic       illegal;
        logic [1:0] resultSrc;
        logic [3:0] aluCtl;
    } ctrl_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic            valid;
        logic [2:0]      funct3;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
    } idEx_t;

    // subEn selects sub for funct3 000 (R-type only); sraEn selects sra for 101.
    function automatic aluOp_e aluFromFunct3(input logic [2:0] funct3, input logic subEn,
                                             input logic sraEn);
        aluOp_e op;
        case (funct3)
            3'b000:  op = subEn ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sraEn ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] immGen(input logic [31:0] i, input immSel_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

    logic [XLEN-1:0] regFile_r [NREGS];
    logic [AW-1:0]   rs1_s, rs2_s, rd_s;
    logic            bypass1_s, bypass2_s;
    logic [XLEN-1:0] rd1_s, rd2_s;
    ctrl_t           decCtrl_s, ctrl_s;
    immSel_e         immSel_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] immExt_s;
    idEx_t           idExNext_s, idEx_r;

    assign rs1_s    = bus.InstrD[15 +: AW];
    assign rs2_s    = bus.InstrD[20 +: AW];
    assign rd_s     = bus.InstrD[7 +: AW];
    assign bus.Rs1D = rs1_s;
    assign bus.Rs2D = rs2_s;

    // Register file storage; x0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regFile_r[i] <= {XLEN{1'b0}};
        end else if (bus.RegWriteW && (bus.RdW != {AW{1'b0}})) begin
            regFile_r[bus.RdW] <= bus.ResultW;
        end
    end

    assign bypass1_s = BYPASS_EN && bus.RegWriteW && (bus.RdW == rs1_s) && (rs1_s != {AW{1'b0}});
    assign bypass2_s = BYPASS_EN && bus.RegWriteW && (bus.RdW == rs2_s) && (rs2_s != {AW{1'b0}});
    assign rd1_s     = bypass1_s ? bus.ResultW : regFile_r[rs1_s];
    assign rd2_s     = bypass2_s ? bus.ResultW : regFile_r[rs2_s];

    // Opcode decode into control fields and immediate format.
    always_comb begin
        decCtrl_s        = '0;
        decCtrl_s.aluCtl = ALU_ADD;
        immSel_s         = IMM_NONE;
        case (bus.InstrD[6:0])
            7'b0000011: begin
                decCtrl_s.regWrite  = 1'b1;
                decCtrl_s.aluSrc    = 1'b1;
                decCtrl_s.resultSrc = 2'b01;
                immSel_s            = IMM_I;
            end
            7'b0100011: begin
                decCtrl_s.memWrite = 1'b1;
                decCtrl_s.aluSrc   = 1'b1;
                immSel_s           = IMM_S;
            end
            7'b0110011: begin
                decCtrl_s.regWrite = 1'b1;
                decCtrl_s.aluCtl   = aluFromFunct3(bus.InstrD[14:12], bus.InstrD[30], bus.InstrD[30]);
            end
            7'b0010011: begin
                decCtrl_s.regWrite = 1'b1;
                decCtrl_s.aluSrc   = 1'b1;
                decCtrl_s.aluCtl   = aluFromFunct3(bus.InstrD[14:12], 1'b0, bus.InstrD[30]);
                immSel_s           = IMM_I;
            end
            7'b1100011: begin
                decCtrl_s.branch = 1'b1;
                decCtrl_s.aluCtl = ALU_SUB;
                immSel_s         = IMM_B;
            end
            7'b1101111: begin
                decCtrl_s.jump      = 1'b1;
                decCtrl_s.regWrite  = 1'b1;
                decCtrl_s.resultSrc = 2'b10;
                immSel_s            = IMM_J;
            end
            7'b0110111: begin
                decCtrl_s.regWrite = 1'b1;
                decCtrl_s.aluSrc   = 1'b1;
                decCtrl_s.aluCtl   = ALU_PASSB;
                immSel_s           = IMM_U;
            end
            default: begin
                decCtrl_s.aluCtl  = ALU_ADD;
                decCtrl_s.illegal = 1'b1;
            end
        endcase
    end

    // A bubble carries no control and is never flagged illegal.
    assign ctrl_s   = bus.ValidD ? decCtrl_s : '0;
    assign imm32_s  = immGen(bus.InstrD, immSel_s);
    assign immExt_s = XLEN'($signed(imm32_s));

    // Assemble the next ID/EX contents.
    always_comb begin
        idExNext_s.ctrl    = ctrl_s;
        idExNext_s.valid   = bus.ValidD;
        idExNext_s.funct3  = bus.InstrD[14:12];
        idExNext_s.rs1     = rs1_s;
        idExNext_s.rs2     = rs2_s;
        idExNext_s.rd      = rd_s;
        idExNext_s.rd1     = rd1_s;
        idExNext_s.rd2     = rd2_s;
        idExNext_s.imm     = immExt_s;
        idExNext_s.pc      = bus.PCD;
        idExNext_s.pcPlus4 = bus.PCPlus4D;
    end

    // ID/EX register: reset, then flush (wins over stall), then stall hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idEx_r <= '0;
        end else if (bus.FlushE) begin
            idEx_r <= '0;
        end else if (!bus.StallE) begin
            idEx_r <= idExNext_s;
        end
    end

    assign bus.RegWriteE   = idEx_r.ctrl.regWrite;
    assign bus.MemWriteE   = idEx_r.ctrl.memWrite;
    assign bus.JumpE       = idEx_r.ctrl.jump;
    assign bus.BranchE     = idEx_r.ctrl.branch;
    assign bus.ALUSrcE     = idEx_r.ctrl.aluSrc;
    assign bus.IllegalE    = idEx_r.ctrl.illegal;
    assign bus.ResultSrcE  = idEx_r.ctrl.resultSrc;
    assign bus.ALUControlE = idEx_r.ctrl.aluCtl;
    assign bus.ValidE      = idEx_r.valid;
    assign bus.Funct3E     = idEx_r.funct3;
    assign bus.Rs1E        = idEx_r.rs1;
    assign bus.Rs2E        = idEx_r.rs2;
    assign bus.RdE         = idEx_r.rd;
    assign bus.RD1E        = idEx_r.rd1;
    assign bus.RD2E        = idEx_r.rd2;
    assign bus.ImmExtE     = idEx_r.imm;
    assign bus.PCE         = idEx_r.pc;
    assign bus.PCPlus4E    = idEx_r.pcPlus4;
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised decode stage for the RISC-V pipeline. Reads the register file, decodes the RV32I subset into 4-bit ALU control, sign-extends immediates to XLEN, and launches everything into the ID/EX pipeline register. Compared with the first-generation stage it adds:
- parametrised data width and register count;
- write-to-read bypass in the register file;
- a hold (stall) input and a valid bit;
- illegal-opcode flagging;
- register-address outputs for the hazard unit.

It sits between the fetch register (IF/ID) and execute.

## Interface
Parameters:
- XLEN, 32: data and PC width (≥ 32). Instructions are always 32 bits.
- NREGS, 32: number of architectural registers (power of 2, ≤ 32). The address width is AW = $clog2(NREGS).
- BYPASS, 1: 1 means a same-cycle writeback is visible on the read ports; 0 means no bypass.

Ports:
- clk  in  1  clock, rising edge active.
- reset  in  1  asynchronous, active-high reset.
- InstrD  in  32  instruction in decode.
- PCD, PCPlus4D  in  XLEN  PC and PC+4 of InstrD.
- ValidD  in  1  InstrD is a real instruction (0 means bubble).
- StallE  in  1  hold the ID/EX register.
- FlushE  in  1  clear the ID/EX register to a bubble.
- RegWriteW  in  1  writeback enable.
- RdW  in  AW  writeback address.
- ResultW  in  XLEN  writeback data.
- Rs1D, Rs2D  out  AW  source addresses of InstrD (combinational, for load-use detection).
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE  out  1  registered control.
- ResultSrcE  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- ALUControlE  out  4  ALU operation.
- Funct3E  out  3  branch condition, forwarded to execute.
- Rs1E, Rs2E, RdE  out  AW  registered register addresses.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  registered data.

## Operation
Register file:
- NREGS×XLEN storage. Register 0 reads 0 and ignores writes.
- Write occurs at posedge clk when RegWriteW=1 and RdW≠0.
- Reads are combinational on Rs1D = InstrD[15+AW-1:15] and Rs2D = InstrD[20+AW-1:20].
- If BYPASS=1 and RegWriteW=1 and RdW equals the read address and that address is ≠0, the read returns ResultW. Otherwise it returns stored contents.
- reset clears every register to 0.

Decode (opcode = InstrD[6:0]):
- 0000011 (load): RegWrite=1, ALUSrc=1, ResultSrc=01, imm I, ALU add.
- 0100011 (store): MemWrite=1, ALUSrc=1, imm S, ALU add.
- 0110011 (R-type): RegWrite=1, ALU from funct3 plus funct7[5].
- 0010011 (I-ALU): RegWrite=1, ALUSrc=1, imm I, ALU from funct3. funct7[5] is used only for shift-right.
- 1100011 (branch): Branch=1, imm B, ALU sub.
- 1101111 (JAL): Jump=1, RegWrite=1, ResultSrc=10, imm J.
- 0110111 (LUI): RegWrite=1, ALUSrc=1, imm U, ALU passB.
- Any other opcode: all control 0 and Illegal=1.
- When ValidD=0, all control is 0 and Illegal=0, regardless of InstrD.

ALUControl encoding:
- 0000 add, 0001 sub (R-type only, funct7[5]=1), 0010 and, 0011 or, 0100 xor.
- 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.

Immediate generation:
- I, S, B and J immediates are sign-extended from InstrD[31] to XLEN.
- U immediate is {InstrD[31:12], 12'b0}, sign-extended to XLEN.

ID/EX register priority, evaluated at posedge clk:
1. reset (asynchronous): all outputs go to 0.
2. FlushE=1: all control fields and ValidE go to 0. Data and address fields also go to 0.
3. StallE=1: all fields hold their current values.
4. Otherwise: load the decoded values, with ValidE=ValidD.

## Timing
- Decode and register read are combinational within the D cycle. Outputs are valid the cycle after capture, so latency is 1 cycle.
- A writeback in cycle N:
  - with BYPASS=1, is seen by an instruction decoded in cycle N;
  - with BYPASS=0, is seen only from cycle N+1.
- FlushE and StallE both high: the flush wins.
- A register-file write proceeds during StallE and FlushE. The stalled RD1E/RD2E values are not refreshed; forwarding is the hazard unit's responsibility.
- Reset asserted mid-operation clears the register file and the ID/EX register immediately, without waiting for a clock edge. Both stay 0 until the first edge after deassertion.

## Test plan
- Reset: assert reset between edges → all outputs 0 immediately; x1..x31 read 0.
- Capture: InstrD=0x00A30293 (addi x5,x6,10) with x6=7 → next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=0000, RD1E=7, ImmExtE=10, RdE=5.
- Bypass: RegWriteW=1, RdW=3, ResultW=0x55 in the same cycle as add x4,x3,x0:
  - with BYPASS=1 → RD1E=0x55;
  - with BYPASS=0 → RD1E=old x3.
- x0 write: RegWriteW=1, RdW=0, ResultW=0xFF → x0 still reads 0, and no bypass occurs for address 0.
- Stall, then flush: StallE=1 for 2 cycles → all E outputs unchanged. Then FlushE=1 together with StallE=1 → ValidE=0 and all control fields 0.
- Illegal and immediates:
  - InstrD opcode 1111111 with ValidD=1 → IllegalE=1 and all control 0.
  - beq with offset −4 → ImmExtE=0xFFFFFFFC (XLEN=32) and ALUControlE=0001.
  - LUI 0x80000 at XLEN=64 → ImmExtE=0xFFFFFFFF80000000.
